// File: rtl/t5_fbuf.sv
// t5_fbuf: fetch return buffer pairing in-order iwb acks with issued {pc,hart} tags for decode
module t5_fbuf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic            istb,
  input  logic [29:0]     ipc,
  input  logic [1:0]      ihart,
  output logic            ifull,
  input  logic            iwb_ack,
  input  logic [XLEN-1:0] iwb_dat,
  input  logic            xkill,
  input  logic [1:0]      xhart,
  output logic            dval,
  output logic [XLEN-1:0] dinst,
  output logic [29:0]     dpc,
  output logic [1:0]      dhart,
  output logic            ierr
);
  logic [AW-1:0]    head, tail, fptr;
  logic [AW:0]      cnt, pend;
  logic [DEPTH-1:0] vld, fil, kil;
  logic [29:0]      pcs [DEPTH];
  logic [1:0]       hts [DEPTH];
  logic [XLEN-1:0]  ins [DEPTH];
  logic             push, fill, pop, hkill;
  assign ifull = cnt == (AW+1)'(DEPTH);
  assign push  = sena && istb && !ifull;
  assign fill  = iwb_ack && pend != '0;
  assign pop   = sena && vld[head] && fil[head];
  assign hkill = xkill && xhart == hts[head];
  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      head  <= '0;
      tail  <= '0;
      fptr  <= '0;
      cnt   <= '0;
      pend  <= '0;
      vld   <= '0;
      fil   <= '0;
      kil   <= '0;
      dval  <= 1'b0;
      dinst <= '0;
      dpc   <= '0;
      dhart <= '0;
      ierr  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pcs[i] <= '0;
        hts[i] <= '0;
        ins[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (xkill && vld[i] && hts[i] == xhart) kil[i] <= 1'b1;
      // the new-path push lands after the kill sweep so it survives a same-cycle kill
      if (push) begin
        vld[tail] <= 1'b1;
        fil[tail] <= 1'b0;
        kil[tail] <= 1'b0;
        pcs[tail] <= ipc;
        hts[tail] <= ihart;
        tail      <= tail + AW'(1);
      end
      if (fill) begin
        ins[fptr] <= iwb_dat;
        fil[fptr] <= 1'b1;
        fptr      <= fptr + AW'(1);
      end
      if (iwb_ack && pend == '0) ierr <= 1'b1;
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + AW'(1);
      end
      if (sena) dval <= pop && !kil[head] && !hkill;
      if (pop) begin
        dinst <= ins[head];
        dpc   <= pcs[head];
        dhart <= hts[head];
      end
      cnt  <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      pend <= pend + (AW+1)'(push) - (AW+1)'(fill);
    end
  end
endmodule

// File: tb/tb_t5_fbuf.sv
// tb_t5_fbuf: directed checks of the fetch return buffer
module tb_t5_fbuf;
  logic        sclk = 0, srst = 0, sena = 0, istb = 0, iwb_ack = 0, xkill = 0;
  logic [29:0] ipc = 0;
  logic [1:0]  ihart = 0, xhart = 0;
  logic [31:0] iwb_dat = 0;
  logic        ifull, dval, ierr;
  logic [31:0] dinst;
  logic [29:0] dpc;
  logic [1:0]  dhart;
  int n_cmp = 0, n_bad = 0;

  t5_fbuf dut (
    .sclk(sclk), .srst(srst), .sena(sena), .istb(istb), .ipc(ipc), .ihart(ihart),
    .ifull(ifull), .iwb_ack(iwb_ack), .iwb_dat(iwb_dat), .xkill(xkill), .xhart(xhart),
    .dval(dval), .dinst(dinst), .dpc(dpc), .dhart(dhart), .ierr(ierr)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic st, input logic [29:0] pc, input logic [1:0] h,
                     input logic a, input logic [31:0] d,
                     input logic xk = 1'b0, input logic [1:0] xh = 2'd0);
    sena = s; istb = st; ipc = pc; ihart = h; iwb_ack = a; iwb_dat = d; xkill = xk; xhart = xh;
    @(negedge sclk);
  endtask

  task automatic dchk(input string tag, input logic v, input logic [29:0] pc = 0,
                      input logic [1:0] h = 0, input logic [31:0] d = 0);
    check({tag, ".dval"}, 64'(dval), 64'(v));
    if (v) begin
      check({tag, ".dpc"}, 64'(dpc), 64'(pc));
      check({tag, ".dhart"}, 64'(dhart), 64'(h));
      check({tag, ".dinst"}, 64'(dinst), 64'(d));
    end
  endtask

  task automatic do_reset();
    sena = 0; istb = 0; iwb_ack = 0; xkill = 0;
    srst = 0;
    @(negedge sclk);
    @(negedge sclk);
    srst = 1;
    @(negedge sclk);
  endtask

  initial begin
    do_reset();
    check("rst.dval", 64'(dval), 0);
    check("rst.dinst", 64'(dinst), 0);
    check("rst.dpc", 64'(dpc), 0);
    check("rst.dhart", 64'(dhart), 0);
    check("rst.ierr", 64'(ierr), 0);
    check("rst.ifull", 64'(ifull), 0);

    // stray ack with nothing outstanding
    cyc(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check("t4.ierr", 64'(ierr), 1);
    dchk("t4", 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("t4.ierr_sticky", 64'(ierr), 1);
    dchk("t4b", 0);

    // four harts in order, ack two cycles after issue
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1, k < 4, 30'h40, 2'(k), k >= 2 && k < 6, 32'hA000_0000 + 32'(k - 2));
      if (k >= 3 && k <= 6) dchk("t1", 1, 30'h40, 2'(k - 3), 32'hA000_0000 + 32'(k - 3));
      else dchk("t1", 0);
    end
    check("t1.ierr", 64'(ierr), 0);

    // full: 4 pushes, fifth ignored, drain
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 30'h10 + 30'(k), 0, 0, 0);
      check("t2.ifull", 64'(ifull), 64'(k == 3));
    end
    cyc(1, 1, 30'h99, 1, 0, 0);
    check("t2.ifull_hold", 64'(ifull), 1);
    cyc(1, 0, 0, 0, 1, 32'hB0);
    check("t2.ifull_fill", 64'(ifull), 1);
    dchk("t2a", 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0, k < 3, 32'hB1 + 32'(k));
      dchk("t2b", 1, 30'h10 + 30'(k), 0, 32'hB0 + 32'(k));
      check("t2.ifull_drop", 64'(ifull), 0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    dchk("t2c", 0);
    check("t2.ierr", 64'(ierr), 0);

    // kill hart1 with one filled and one unfilled entry
    do_reset();
    cyc(1, 1, 30'h1, 0, 0, 0);
    cyc(1, 1, 30'h2, 1, 0, 0);
    cyc(1, 1, 30'h3, 1, 0, 0);
    cyc(1, 1, 30'h4, 2, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hC0);
    cyc(0, 0, 0, 0, 1, 32'hC1);
    dchk("t3f", 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'd1);
    cyc(1, 0, 0, 0, 1, 32'hC2);
    dchk("t3a", 1, 30'h1, 0, 32'hC0);
    cyc(1, 0, 0, 0, 1, 32'hC3);
    dchk("t3b", 0);
    cyc(1, 0, 0, 0, 0, 0);
    dchk("t3c", 0);
    cyc(1, 0, 0, 0, 0, 0);
    dchk("t3d", 1, 30'h4, 2, 32'hC3);
    cyc(1, 1, 30'h6, 2, 0, 0, 1, 2'd2);
    dchk("t3e", 0);
    cyc(1, 0, 0, 0, 1, 32'hC6);
    dchk("t3g", 0);
    cyc(1, 0, 0, 0, 0, 0);
    dchk("t3h", 1, 30'h6, 2, 32'hC6);
    cyc(1, 0, 0, 0, 0, 0);
    dchk("t3i", 0);
    check("t3.ierr", 64'(ierr), 0);

    // acks while sena=0, then drain with one stall
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1, 1, 30'h20 + 30'(k), 3, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 1, 32'hD0 + 32'(k));
      dchk("t5f", 0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    dchk("t5a", 1, 30'h20, 3, 32'hD0);
    cyc(0, 0, 0, 0, 0, 0);
    dchk("t5hold", 1, 30'h20, 3, 32'hD0);
    cyc(1, 0, 0, 0, 0, 0);
    dchk("t5b", 1, 30'h21, 3, 32'hD1);
    cyc(1, 0, 0, 0, 0, 0);
    dchk("t5c", 1, 30'h22, 3, 32'hD2);
    cyc(1, 0, 0, 0, 0, 0);
    dchk("t5d", 0);

    // async reset mid-stream
    do_reset();
    cyc(1, 1, 30'h30, 0, 0, 0);
    cyc(1, 1, 30'h31, 0, 1, 32'hE0);
    cyc(1, 1, 30'h32, 0, 0, 0);
    dchk("t6pre", 1, 30'h30, 0, 32'hE0);
    sena = 0; istb = 0; iwb_ack = 0;
    srst = 0;
    #1;
    check("t6.dval", 64'(dval), 0);
    check("t6.dinst", 64'(dinst), 0);
    check("t6.dpc", 64'(dpc), 0);
    check("t6.dhart", 64'(dhart), 0);
    check("t6.ifull", 64'(ifull), 0);
    @(negedge sclk);
    srst = 1;
    cyc(0, 0, 0, 0, 1, 32'hE1);
    check("t6.stale_ierr", 64'(ierr), 1);
    cyc(1, 1, 30'h50, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'hE5);
    dchk("t6a", 0);
    cyc(1, 0, 0, 0, 0, 0);
    dchk("t6b", 1, 30'h50, 1, 32'hE5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
